// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
// Provides the bus types, the zero word shown to decode when nothing is
// available, reset/chip-enable levels, the fetch FSM state encoding, the
// FIFO entry layout and the sequential-PC helper.
package inst_fetch_pkg;

    typedef logic [31:0] InstAddrBus;
    typedef logic [31:0] InstBus;

    localparam InstBus ZeroWord    = 32'h0000_0000;
    localparam logic   RstEnable   = 1'b1;
    localparam logic   ChipEnable  = 1'b1;
    localparam logic   ChipDisable = 1'b0;

    // IF_DRAIN: a wrong-path request is still on the ROM bus and must be
    // allowed to complete before a new address can be presented.
    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_REQ   = 2'd1,
        IF_DRAIN = 2'd2
    } if_state_e;

    // One prefetch buffer entry: {pc, inst}, 64 bits.
    typedef struct packed {
        InstAddrBus pc;
        InstBus     inst;
    } fetch_entry_t;

    // Sequential fetch address; wraps modulo 2^32.
    function automatic InstAddrBus next_pc(input InstAddrBus pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// inst_fifo: synchronous FIFO of 64-bit {pc, inst} entries.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   i_push/i_data write one entry (ignored when full)
//   i_pop         drop the head entry (ignored when empty)
//   i_clear       empty the FIFO; wins over push and pop
//   o_head        current head entry (combinational from storage)
//   o_count       number of valid entries, 0..DEPTH
module inst_fifo
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [63:0]              i_data,
    input  logic                     i_pop,
    input  logic                     i_clear,
    output logic [63:0]              o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] Full = CW'(DEPTH);

    logic [63:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_push = i_push && (r_count != Full);
    assign w_do_pop  = i_pop  && (r_count != '0);

    // Entry storage carries no reset; the count qualifies its contents.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch unit feeding the decode stage.
// Issues single-outstanding requests to a variable-latency instruction ROM,
// buffers returned words in inst_fifo and presents the head {pc, inst}.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   stall_i                     decode not accepting; head is held
//   flush_i, new_pc_i           redirect to new_pc_i (overrides stall_i)
//   rom_ce_o, rom_addr_o        registered ROM request
//   rom_ready_i, rom_data_i     request completion and its instruction word
//   inst_valid_o, pc_o, inst_o  head entry to decode (zeros when empty)
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] new_pc_i,
    output logic        rom_ce_o,
    output logic [31:0] rom_addr_o,
    input  logic        rom_ready_i,
    input  logic [31:0] rom_data_i,
    output logic        inst_valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DepthC = CW'(FIFO_DEPTH);

    if_state_e    r_state, w_state_next;
    InstAddrBus   r_fetch_pc, w_fetch_pc_next;
    InstAddrBus   r_rom_addr, w_rom_addr_next;
    logic         r_rom_ce, w_rom_ce_next;
    logic         w_push;
    logic         w_pop;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_after_push;
    fetch_entry_t w_push_entry;
    fetch_entry_t w_head;

    assign w_pop              = inst_valid_o && !stall_i && !flush_i;
    assign w_count_after_push = w_count + CW'(1) - CW'(w_pop);
    assign w_push_entry       = '{pc: r_rom_addr, inst: rom_data_i};

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            r_state    <= IF_IDLE;
            r_fetch_pc <= RESET_PC;
            r_rom_addr <= '0;
            r_rom_ce   <= ChipDisable;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            r_rom_addr <= w_rom_addr_next;
            r_rom_ce   <= w_rom_ce_next;
        end
    end

    // r_fetch_pc always equals the address of the request in flight (or the
    // next one to issue), so completion simply advances it by one word.
    always_comb begin
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        w_rom_addr_next = r_rom_addr;
        w_rom_ce_next   = r_rom_ce;
        w_push          = 1'b0;
        case (r_state)
            IF_IDLE: begin
                if (flush_i) begin
                    w_state_next    = IF_REQ;
                    w_fetch_pc_next = new_pc_i;
                    w_rom_addr_next = new_pc_i;
                    w_rom_ce_next   = ChipEnable;
                end else if (w_count < DepthC) begin
                    w_state_next    = IF_REQ;
                    w_rom_addr_next = r_fetch_pc;
                    w_rom_ce_next   = ChipEnable;
                end
            end
            IF_REQ: begin
                if (flush_i) begin
                    w_fetch_pc_next = new_pc_i;
                    if (rom_ready_i) begin
                        // Returned word is wrong-path; drop it and redirect now.
                        w_rom_addr_next = new_pc_i;
                    end else begin
                        // Address must stay on the bus until the ROM completes.
                        w_state_next = IF_DRAIN;
                    end
                end else if (rom_ready_i) begin
                    w_push          = 1'b1;
                    w_fetch_pc_next = next_pc(r_fetch_pc);
                    if (w_count_after_push < DepthC) begin
                        w_rom_addr_next = next_pc(r_fetch_pc);
                    end else begin
                        w_state_next  = IF_IDLE;
                        w_rom_ce_next = ChipDisable;
                    end
                end
            end
            IF_DRAIN: begin
                if (flush_i) begin
                    w_fetch_pc_next = new_pc_i;
                end
                if (rom_ready_i) begin
                    w_state_next    = IF_REQ;
                    w_rom_addr_next = flush_i ? new_pc_i : r_fetch_pc;
                end
            end
            default: begin
                w_state_next  = IF_IDLE;
                w_rom_ce_next = ChipDisable;
            end
        endcase
    end

    inst_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .i_clear (flush_i),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign rom_ce_o     = r_rom_ce;
    assign rom_addr_o   = r_rom_addr;
    assign inst_valid_o = (w_count != '0);
    assign pc_o         = inst_valid_o ? w_head.pc   : '0;
    assign inst_o       = inst_valid_o ? w_head.inst : ZeroWord;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] new_pc_i;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic        rom_ready_i;
    logic [31:0] rom_data_i;
    logic        inst_valid_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;

    int errors = 0;
    int checks = 0;
    int rom_wait = 0;
    bit rom_random = 0;
    int rom_wc = 0;

    inst_fetch #(
        .FIFO_DEPTH (2),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .new_pc_i     (new_pc_i),
        .rom_ce_o     (rom_ce_o),
        .rom_addr_o   (rom_addr_o),
        .rom_ready_i  (rom_ready_i),
        .rom_data_i   (rom_data_i),
        .inst_valid_o (inst_valid_o),
        .pc_o         (pc_o),
        .inst_o       (inst_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: ROM[word i] = i, i.e. data = address >> 2. Either a fixed
    // number of wait cycles per request, or a random ready.
    initial begin
        rom_ready_i = 1'b0;
        rom_data_i  = '0;
        forever begin
            @(negedge clk);
            if (rom_ce_o === 1'b1 && rst === 1'b0) begin
                if (rom_random) rom_ready_i = ($urandom_range(0, 1) == 1);
                else            rom_ready_i = (rom_wc >= rom_wait);
                if (rom_ready_i) rom_wc = 0;
                else             rom_wc++;
                rom_data_i = rom_addr_o >> 2;
            end else begin
                rom_ready_i = 1'b0;
                rom_wc      = 0;
                rom_data_i  = $urandom;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Advance to the next cycle: drive inputs at the falling edge, then move
    // 1 time unit later where outputs are sampled.
    task automatic step(input bit st, input bit fl, input logic [31:0] np);
        @(negedge clk);
        stall_i  = st;
        flush_i  = fl;
        new_pc_i = np;
        #1;
    endtask

    // Leaves the bench at the sample point of cycle 1 after reset release.
    task automatic do_reset();
        rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; new_pc_i = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rom_wait = 0; rom_random = 0;
        rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; new_pc_i = '0;
        @(negedge clk); #1;
        checks++; if (rom_ce_o !== 1'b0) begin errors++; $display("FAIL rst_ce: got %b expected 0", rom_ce_o); end
        checks++; if (rom_addr_o !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", rom_addr_o); end
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", inst_valid_o); end
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h expected 0", pc_o); end
        checks++; if (inst_o !== 32'h0) begin errors++; $display("FAIL rst_inst: got %h expected 0", inst_o); end
        @(negedge clk); rst = 1'b0; #1;
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) step(0, 0, 32'h0);
            checks++; if (rom_ce_o !== (k >= 2)) begin errors++; $display("FAIL seq_ce c%0d: got %b expected %b", k, rom_ce_o, (k >= 2)); end
            if (k >= 2) begin
                checks++; if (rom_addr_o !== 32'(4 * (k - 2))) begin errors++; $display("FAIL seq_addr c%0d: got %h expected %h", k, rom_addr_o, 32'(4 * (k - 2))); end
            end
            checks++; if (inst_valid_o !== (k >= 3)) begin errors++; $display("FAIL seq_valid c%0d: got %b expected %b", k, inst_valid_o, (k >= 3)); end
            if (k >= 3) begin
                $display("pop pc=%h inst=%h", pc_o, inst_o);
                checks++; if (pc_o !== 32'(4 * (k - 3))) begin errors++; $display("FAIL seq_pc c%0d: got %h expected %h", k, pc_o, 32'(4 * (k - 3))); end
                checks++; if (inst_o !== 32'(k - 3)) begin errors++; $display("FAIL seq_inst c%0d: got %h expected %h", k, inst_o, 32'(k - 3)); end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] q[$];
        logic [31:0] exp_pcs [4];
        exp_pcs[0] = 32'h8; exp_pcs[1] = 32'hC; exp_pcs[2] = 32'h10; exp_pcs[3] = 32'h14;
        rom_wait = 0; rom_random = 0;
        do_reset();
        for (int k = 2; k <= 4; k++) step(0, 0, 32'h0);
        for (int k = 5; k <= 9; k++) begin
            step(1, 0, 32'h0);
            checks++; if (inst_valid_o !== 1'b1 || pc_o !== 32'h8) begin errors++; $display("FAIL stall_head c%0d: got valid=%b pc=%h expected valid=1 pc=00000008", k, inst_valid_o, pc_o); end
            if (k >= 6) begin
                checks++; if (rom_ce_o !== 1'b0) begin errors++; $display("FAIL stall_ce c%0d: got %b expected 0", k, rom_ce_o); end
            end
        end
        for (int k = 10; k <= 20; k++) begin
            step(0, 0, 32'h0);
            if (inst_valid_o === 1'b1) begin
                $display("pop pc=%h inst=%h", pc_o, inst_o);
                q.push_back(pc_o);
                checks++; if (inst_o !== (pc_o >> 2)) begin errors++; $display("FAIL stall_inst: got %h expected %h", inst_o, pc_o >> 2); end
            end
        end
        checks++; if (q.size() < 4) begin errors++; $display("FAIL stall_count: got %0d expected >=4", q.size()); end
        for (int i = 0; i < 4 && i < q.size(); i++) begin
            checks++; if (q[i] !== exp_pcs[i]) begin errors++; $display("FAIL stall_order[%0d]: got %h expected %h", i, q[i], exp_pcs[i]); end
        end
    endtask

    task automatic test_wait_flush();
        rom_wait = 3; rom_random = 0;
        do_reset();
        for (int k = 2; k <= 16; k++) begin
            step(0, (k == 7), 32'h100);
            if (inst_valid_o === 1'b1) $display("pop pc=%h inst=%h", pc_o, inst_o);
            if (k == 6) begin
                checks++; if (inst_valid_o !== 1'b1 || pc_o !== 32'h0) begin errors++; $display("FAIL wf_first c6: got valid=%b pc=%h expected valid=1 pc=0", inst_valid_o, pc_o); end
            end
            if (k >= 7 && k <= 9) begin
                checks++; if (rom_ce_o !== 1'b1 || rom_addr_o !== 32'h4) begin errors++; $display("FAIL wf_drain_addr c%0d: got ce=%b addr=%h expected ce=1 addr=4", k, rom_ce_o, rom_addr_o); end
            end
            if (k == 10) begin
                checks++; if (rom_ce_o !== 1'b1 || rom_addr_o !== 32'h100) begin errors++; $display("FAIL wf_redirect c10: got ce=%b addr=%h expected ce=1 addr=100", rom_ce_o, rom_addr_o); end
            end
            if (k >= 7 && k <= 13) begin
                checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL wf_nodata c%0d: got valid=%b pc=%h expected valid=0", k, inst_valid_o, pc_o); end
            end
            if (k == 14) begin
                checks++; if (inst_valid_o !== 1'b1 || pc_o !== 32'h100 || inst_o !== 32'h40) begin errors++; $display("FAIL wf_target c14: got valid=%b pc=%h inst=%h expected 1 100 40", inst_valid_o, pc_o, inst_o); end
            end
        end
    endtask

    task automatic test_flush_ready();
        logic [31:0] q[$];
        logic [31:0] np;
        rom_wait = 2; rom_random = 0;
        do_reset();
        for (int k = 2; k <= 16; k++) begin
            np = (k == 6) ? 32'h300 : 32'h200;
            step(0, (k >= 4 && k <= 6), np);
            if (k == 4) begin
                checks++; if (rom_ce_o !== 1'b1 || rom_addr_o !== 32'h0 || rom_ready_i !== 1'b1) begin errors++; $display("FAIL fr_ready c4: got ce=%b addr=%h rdy=%b expected 1 0 1", rom_ce_o, rom_addr_o, rom_ready_i); end
            end
            if (k >= 5 && k <= 7) begin
                checks++; if (rom_addr_o !== 32'h200) begin errors++; $display("FAIL fr_addr200 c%0d: got %h expected 200", k, rom_addr_o); end
            end
            if (k == 8) begin
                checks++; if (rom_ce_o !== 1'b1 || rom_addr_o !== 32'h300) begin errors++; $display("FAIL fr_addr300 c8: got ce=%b addr=%h expected 1 300", rom_ce_o, rom_addr_o); end
            end
            if (k >= 5 && k <= 10) begin
                checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL fr_nodata c%0d: got valid=%b pc=%h expected valid=0", k, inst_valid_o, pc_o); end
            end
            if (k == 11) begin
                checks++; if (inst_valid_o !== 1'b1 || pc_o !== 32'h300 || inst_o !== 32'hC0) begin errors++; $display("FAIL fr_target c11: got valid=%b pc=%h inst=%h expected 1 300 c0", inst_valid_o, pc_o, inst_o); end
            end
            if (inst_valid_o === 1'b1 && k >= 7) begin
                $display("pop pc=%h inst=%h", pc_o, inst_o);
                q.push_back(pc_o);
            end
        end
        checks++; if (q.size() < 2 || q[0] !== 32'h300 || q[1] !== 32'h304) begin errors++; $display("FAIL fr_stream: got %0d entries first=%h expected 300,304", q.size(), (q.size() > 0) ? q[0] : 32'hX); end
    endtask

    task automatic test_wrap();
        logic [31:0] q[$];
        logic [31:0] exp_pcs [4];
        exp_pcs[0] = 32'hFFFF_FFF8; exp_pcs[1] = 32'hFFFF_FFFC; exp_pcs[2] = 32'h0; exp_pcs[3] = 32'h4;
        rom_wait = 0; rom_random = 0;
        do_reset();
        for (int k = 2; k <= 14; k++) begin
            step(0, (k == 4), 32'hFFFF_FFF8);
            if (k > 4 && inst_valid_o === 1'b1) begin
                $display("pop pc=%h inst=%h", pc_o, inst_o);
                q.push_back(pc_o);
                checks++; if (inst_o !== (pc_o >> 2)) begin errors++; $display("FAIL wrap_inst: got %h expected %h", inst_o, pc_o >> 2); end
            end
        end
        checks++; if (q.size() < 4) begin errors++; $display("FAIL wrap_count: got %0d expected >=4", q.size()); end
        for (int i = 0; i < 4 && i < q.size(); i++) begin
            checks++; if (q[i] !== exp_pcs[i]) begin errors++; $display("FAIL wrap_pc[%0d]: got %h expected %h", i, q[i], exp_pcs[i]); end
        end
    endtask

    task automatic test_async_reset();
        rom_wait = 3; rom_random = 0;
        do_reset();
        for (int k = 2; k <= 6; k++) step(1, 0, 32'h0);
        checks++; if (inst_valid_o !== 1'b1 || rom_ce_o !== 1'b1) begin errors++; $display("FAIL ar_pre: got valid=%b ce=%b expected 1 1", inst_valid_o, rom_ce_o); end
        #2 rst = 1'b1;
        #1;
        checks++; if (rom_ce_o !== 1'b0) begin errors++; $display("FAIL ar_ce: got %b expected 0", rom_ce_o); end
        checks++; if (inst_valid_o !== 1'b0 || pc_o !== 32'h0 || inst_o !== 32'h0) begin errors++; $display("FAIL ar_out: got valid=%b pc=%h inst=%h expected 0 0 0", inst_valid_o, pc_o, inst_o); end
        stall_i = 1'b0; rom_wait = 0;
        @(negedge clk); @(negedge clk); rst = 1'b0; #1;
        step(0, 0, 32'h0);
        checks++; if (rom_ce_o !== 1'b1 || rom_addr_o !== 32'h0) begin errors++; $display("FAIL ar_restart_addr: got ce=%b addr=%h expected 1 0", rom_ce_o, rom_addr_o); end
        step(0, 0, 32'h0);
        checks++; if (inst_valid_o !== 1'b1 || pc_o !== 32'h0) begin errors++; $display("FAIL ar_restart_pc: got valid=%b pc=%h expected 1 0", inst_valid_o, pc_o); end
    endtask

    // Reference: the delivered stream is the sequential program starting at
    // the last redirect target (or RESET_PC), one word per accepted head.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] np;
        logic [31:0] prev_addr;
        bit st, fl, prev_ce, prev_rdy;
        int pops;
        rom_random = 1;
        do_reset();
        exp_pc = 32'h0; pops = 0;
        prev_ce = rom_ce_o; prev_addr = rom_addr_o; prev_rdy = rom_ready_i;
        for (int n = 0; n < 600; n++) begin
            st = ($urandom_range(0, 9) < 3);
            fl = ($urandom_range(0, 19) == 0);
            np = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            step(st, fl, np);
            if (prev_ce && !prev_rdy) begin
                checks++; if (rom_ce_o !== 1'b1 || rom_addr_o !== prev_addr) begin errors++; $display("FAIL rnd_hold n%0d: got ce=%b addr=%h expected 1 %h", n, rom_ce_o, rom_addr_o, prev_addr); end
            end
            if (inst_valid_o === 1'b1) begin
                checks++; if (pc_o !== exp_pc || inst_o !== (exp_pc >> 2)) begin errors++; $display("FAIL rnd_head n%0d: got pc=%h inst=%h expected %h %h", n, pc_o, inst_o, exp_pc, exp_pc >> 2); end
            end else begin
                checks++; if (pc_o !== 32'h0 || inst_o !== 32'h0) begin errors++; $display("FAIL rnd_empty n%0d: got pc=%h inst=%h expected 0 0", n, pc_o, inst_o); end
            end
            if (fl) begin
                exp_pc = np;
            end else if (inst_valid_o === 1'b1 && !st) begin
                $display("pop pc=%h inst=%h", pc_o, inst_o);
                pops++;
                exp_pc = exp_pc + 32'd4;
            end
            prev_ce = rom_ce_o; prev_addr = rom_addr_o; prev_rdy = rom_ready_i;
        end
        checks++; if (pops < 40) begin errors++; $display("FAIL rnd_progress: got %0d pops expected >=40", pops); end
        rom_random = 0;
    endtask

    initial begin
        rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; new_pc_i = '0;
        test_reset();
        test_stall();
        test_wait_flush();
        test_flush_ready();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
